// File: rtl/buttons_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buttons_pkg : event kinds, per-button states and queued event record.
// Rev 1.0
// ----------------------------------------------------------------------------
package buttons_pkg;

  // Wide enough for the largest supported button count (8)
  localparam int BUTTON_W = 3;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    HOLD    = 2'd2,
    REPEAT  = 2'd3
  } event_kind_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } button_state_t;

  typedef struct packed {
    logic [BUTTON_W-1:0] button;
    event_kind_t         kind;
  } button_event_t;

endpackage
`default_nettype wire

// File: rtl/buttons_event_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buttons_event_fifo : synchronous FIFO of button events, wrap-bit pointers.
// Rev 1.0
// ----------------------------------------------------------------------------
module buttons_event_fifo
  import buttons_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  button_event_t                    wdata,
  output button_event_t                    rdata,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  button_event_t mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        mem[j] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/buttons_event_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// buttons_event_controller : button levels to press/release/hold/repeat queue.
// Rev 1.0
// ----------------------------------------------------------------------------
module buttons_event_controller
  import buttons_pkg::*;
#(
  parameter int BUTTONS      = 4,
  parameter int HOLD_TICKS   = 50_000_000,
  parameter int REPEAT_TICKS = 10_000_000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BUTTONS-1:0]               buttons,
  output logic                             event_valid,
  output logic [$clog2(BUTTONS)-1:0]       event_button,
  output event_kind_t                      event_kind,
  input  logic                             event_ack,
  output logic                             overflow,
  input  logic                             clear_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_count
);

  localparam int IDX_W   = $clog2(BUTTONS);
  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [BUTTONS-1:0] btn_q;
  logic [BUTTONS-1:0] btn_prev;
  logic [BUTTONS-1:0] rise;
  logic [BUTTONS-1:0] fall;
  logic [BUTTONS-1:0] slot_valid;
  logic [BUTTONS-1:0] grant;
  logic [BUTTONS-1:0] drop;
  event_kind_t        slot_kind [BUTTONS];

  button_event_t win;
  button_event_t head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          can_push;
  logic          unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= '0;
      btn_prev <= '0;
    end else begin
      btn_q    <= buttons;
      btn_prev <= btn_q;
    end
  end

  assign rise = btn_q & ~btn_prev;
  assign fall = ~btn_q & btn_prev;

  for (genvar i = 0; i < BUTTONS; i++) begin : g_button
    button_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             gen;
    event_kind_t      gen_kind;
    logic             valid_r;
    event_kind_t      kind_r;

    // Release wins over a hold/repeat falling due in the same cycle
    always_comb begin
      gen      = 1'b0;
      gen_kind = PRESS;
      case (state)
        IDLE: begin
          if (rise[i]) begin
            gen      = 1'b1;
            gen_kind = PRESS;
          end
        end
        PRESSED: begin
          if (fall[i]) begin
            gen      = 1'b1;
            gen_kind = RELEASE;
          end else if (cnt == CNT_W'(HOLD_TICKS - 1)) begin
            gen      = 1'b1;
            gen_kind = HOLD;
          end
        end
        HELD: begin
          if (fall[i]) begin
            gen      = 1'b1;
            gen_kind = RELEASE;
          end else if (REPEAT_TICKS != 0 && cnt == CNT_W'(REPEAT_TICKS - 1)) begin
            gen      = 1'b1;
            gen_kind = REPEAT;
          end
        end
        default: begin
          gen      = 1'b0;
          gen_kind = PRESS;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise[i]) begin
              state <= PRESSED;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (fall[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_W'(HOLD_TICKS - 1)) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (fall[i]) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (REPEAT_TICKS != 0) begin
              if (cnt == CNT_W'(REPEAT_TICKS - 1)) begin
                cnt <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    // Slot freed by the arbiter this cycle may take the new event at once
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_r <= 1'b0;
        kind_r  <= PRESS;
      end else if (gen && (!valid_r || grant[i])) begin
        valid_r <= 1'b1;
        kind_r  <= gen_kind;
      end else if (grant[i]) begin
        valid_r <= 1'b0;
      end
    end

    assign drop[i]       = gen & valid_r & ~grant[i];
    assign slot_valid[i] = valid_r;
    assign slot_kind[i]  = kind_r;
  end

  assign event_valid = ~fifo_empty;
  assign pop         = event_ack & event_valid;
  assign can_push    = ~fifo_full | pop;

  // Descending scan leaves the lowest pending index as the winner
  always_comb begin
    grant = '0;
    win   = '0;
    for (int i = BUTTONS - 1; i >= 0; i--) begin
      if (slot_valid[i]) begin
        grant      = '0;
        grant[i]   = can_push;
        win.button = BUTTON_W'(i);
        win.kind   = slot_kind[i];
      end
    end
  end

  buttons_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (|grant),
    .pop   (pop),
    .wdata (win),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_count)
  );

  assign event_button = head.button[IDX_W-1:0];
  assign event_kind   = head.kind;
  assign unused_bits  = ^head.button;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buttons_event_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_buttons_event_controller : directed stimulus with a queued scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_buttons_event_controller;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_HOLD    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int btn;
    int kind;
    int cyc;   // -1 means any cycle
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] buttons = '0;
  logic       event_valid;
  logic [1:0] event_button;
  logic [1:0] event_kind;
  logic       event_ack = 1'b0;
  logic       overflow;
  logic       clear_overflow = 1'b0;
  logic [2:0] pending_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   e0;
  exp_t exp_q[$];
  exp_t mon_e;

  buttons_event_controller #(
    .BUTTONS      (4),
    .HOLD_TICKS   (8),
    .REPEAT_TICKS (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .buttons        (buttons),
    .event_valid    (event_valid),
    .event_button   (event_button),
    .event_kind     (event_kind),
    .event_ack      (event_ack),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .pending_count  (pending_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted handshake is matched against the scoreboard head
  always @(negedge clk) begin
    if (!rst && event_valid && event_ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got btn=%0d kind=%0d at cycle %0d, expected none",
                 event_button, event_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(event_button) != mon_e.btn || int'(event_kind) != mon_e.kind ||
            (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          miscompares++;
          $display("FAIL event: got btn=%0d kind=%0d cycle=%0d, expected btn=%0d kind=%0d cycle=%0d",
                   event_button, event_kind, cyc, mon_e.btn, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int btn, input int kind, input int at);
    exp_t e;
    e.btn  = btn;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_scoreboard_left"}, exp_q.size(), 0);
    check({name, "_valid"}, int'(event_valid), 0);
    check({name, "_count"}, int'(pending_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(3);
    check("rst_valid", int'(event_valid), 0);
    check("rst_button", int'(event_button), 0);
    check("rst_kind", int'(event_kind), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_count", int'(pending_count), 0);
    rst = 1'b0;

    // Single tap on button 2
    event_ack = 1'b1;
    tick(1); e0 = cyc;
    buttons = 4'b0100;
    expect_ev(2, K_PRESS, e0 + 3);
    tick(3);
    buttons = 4'b0000;
    expect_ev(2, K_RELEASE, e0 + 6);
    tick(6);
    check_drained("tap");
    check("tap_overflow", int'(overflow), 0);

    // Hold and repeat on button 0; release collides with a due repeat
    tick(1); e0 = cyc;
    buttons = 4'b0001;
    expect_ev(0, K_PRESS,   e0 + 3);
    expect_ev(0, K_HOLD,    e0 + 11);
    expect_ev(0, K_REPEAT,  e0 + 15);
    expect_ev(0, K_REPEAT,  e0 + 19);
    expect_ev(0, K_RELEASE, e0 + 23);
    tick(20);
    buttons = 4'b0000;
    tick(6);
    check_drained("hold");

    // Simultaneous rise on buttons 3 and 1
    tick(1); e0 = cyc;
    buttons = 4'b1010;
    expect_ev(1, K_PRESS, e0 + 3);
    expect_ev(3, K_PRESS, e0 + 4);
    tick(4);
    buttons = 4'b0000;
    expect_ev(1, K_RELEASE, e0 + 7);
    expect_ev(3, K_RELEASE, e0 + 8);
    tick(6);
    check_drained("simul");

    // Full queue: releases wait in their slots
    event_ack = 1'b0;
    tick(1); e0 = cyc;
    buttons = 4'b1111;
    for (int b = 0; b < 4; b++) expect_ev(b, K_PRESS, -1);
    tick(8);
    buttons = 4'b0000;
    for (int b = 0; b < 4; b++) expect_ev(b, K_RELEASE, -1);
    tick(4);
    check("full_count", int'(pending_count), 4);
    check("full_valid", int'(event_valid), 1);
    check("full_head_button", int'(event_button), 0);
    event_ack = 1'b1;
    tick(12);
    check_drained("full");
    check("full_overflow", int'(overflow), 0);

    // Overflow: button 0 release collides with its pending press
    event_ack = 1'b0;
    tick(1); e0 = cyc;
    buttons = 4'b0110;
    expect_ev(1, K_PRESS, -1);
    expect_ev(2, K_PRESS, -1);
    tick(2);
    buttons = 4'b0000;
    expect_ev(1, K_RELEASE, -1);
    expect_ev(2, K_RELEASE, -1);
    tick(5);
    buttons = 4'b0001;
    expect_ev(0, K_PRESS, -1);
    tick(2);
    buttons = 4'b0000;
    tick(1);
    check("ovf_before", int'(overflow), 0);
    check("ovf_count", int'(pending_count), 4);
    tick(1);
    check("ovf_set", int'(overflow), 1);
    clear_overflow = 1'b1;
    tick(1);
    check("ovf_cleared", int'(overflow), 0);
    clear_overflow = 1'b0;
    event_ack = 1'b1;
    tick(10);
    check_drained("ovf");

    // Reset with three events queued and button 0 still held
    event_ack = 1'b0;
    tick(1); e0 = cyc;
    buttons = 4'b0111;
    tick(6);
    check("rstq_count_before", int'(pending_count), 3);
    rst = 1'b1;
    buttons = 4'b0001;
    tick(1);
    check("rstq_valid", int'(event_valid), 0);
    check("rstq_count", int'(pending_count), 0);
    rst = 1'b0;
    event_ack = 1'b1;
    expect_ev(0, K_PRESS, e0 + 10);
    tick(3);
    buttons = 4'b0000;
    expect_ev(0, K_RELEASE, e0 + 13);
    tick(6);
    check_drained("rstq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
